// File: rtl/csr_timer_array_if.sv
// Register-access bus between the CSR unit and the timer array.
// The master drives writes and read selects. The slave returns combinational read data.
interface csr_timer_array_if #(
   parameter int TW  = 32,
   parameter int CHW = 1
);
   logic           wr_en;
   logic [CHW-1:0] wr_ch;
   logic           wr_sel;
   logic [TW-1:0]  wr_data;
   logic [CHW-1:0] rd_ch;
   logic [1:0]     rd_sel;
   logic [TW-1:0]  rd_data;

   modport master (
      output wr_en, wr_ch, wr_sel, wr_data, rd_ch, rd_sel,
      input  rd_data
   );

   modport slave (
      input  wr_en, wr_ch, wr_sel, wr_data, rd_ch, rd_sel,
      output rd_data
   );
endinterface

// File: rtl/csr_timer_array.sv
// N_TIMER countdown timers with one-shot and periodic modes and sticky write-1-to-clear interrupts.
// Also provides a prescaled free-running stable counter that freeze does not stop.
module csr_timer_array #(
   parameter int N_TIMER = 2,
   parameter int TW      = 32,
   parameter int CNT_W   = 64,
   parameter int DIV     = 1,
   parameter int CHW     = (N_TIMER > 1) ? $clog2(N_TIMER) : 1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               freeze,
   csr_timer_array_if.slave   bus,
   output logic [CNT_W-1:0]   cnt,
   output logic [N_TIMER-1:0] irq,
   output logic               irq_any
);
   localparam int             PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CHW:0]   N_CH = (CHW + 1)'(N_TIMER);

   logic [N_TIMER-1:0][TW-1:0] tcfg_q, tcfg_d;
   logic [N_TIMER-1:0][TW-1:0] tval_q, tval_d;
   logic [N_TIMER-1:0]         en_q, en_d;
   logic [N_TIMER-1:0]         ti_q, ti_d;
   logic [PW-1:0]              pre_q, pre_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [TW-1:0]              rd_data;

   always_comb begin
      // NOTE: every next-state signal gets a default first, so no path can infer a latch.
      tcfg_d = tcfg_q;
      tval_d = tval_q;
      en_d   = en_q;
      ti_d   = ti_q;
      for (int i = 0; i < N_TIMER; i++) begin
         if (bus.wr_en && bus.wr_sel && bus.wr_data[0] && bus.wr_ch == CHW'(i))
            ti_d[i] = 1'b0;
         // A TCFG write pre-empts the tick. An expiry, applied after the clear, wins over TICLR.
         if (bus.wr_en && !bus.wr_sel && bus.wr_ch == CHW'(i)) begin
            tcfg_d[i] = bus.wr_data;
            tval_d[i] = {bus.wr_data[TW-1:2], 2'b00};
            en_d[i]   = bus.wr_data[0];
         end else if (en_q[i] && !freeze) begin
            if (tval_q[i] != '0) begin
               tval_d[i] = tval_q[i] - TW'(1);
            end else begin
               ti_d[i] = 1'b1;
               if (tcfg_q[i][1]) begin
                  tval_d[i] = {tcfg_q[i][TW-1:2], 2'b00};
               end else begin
                  tval_d[i] = '1;
                  en_d[i]   = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      pre_d = pre_q + PW'(1);
      cnt_d = cnt_q;
      if (pre_q == PW'(DIV - 1)) begin
         pre_d = '0;
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: the timer state is a small set of control flops, not a RAM, so every element is reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tcfg_q <= '0;
         tval_q <= '0;
         en_q   <= '0;
         ti_q   <= '0;
         pre_q  <= '0;
         cnt_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
         tcfg_q <= tcfg_d;
         tval_q <= tval_d;
         en_q   <= en_d;
         ti_q   <= ti_d;
         pre_q  <= pre_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      rd_data = '0;
      if ({1'b0, bus.rd_ch} < N_CH) begin
         case (bus.rd_sel)
            2'd0:    rd_data = tcfg_q[bus.rd_ch];
            2'd1:    rd_data = tval_q[bus.rd_ch];
            2'd2:    rd_data = {{(TW - 1){1'b0}}, ti_q[bus.rd_ch]};
            default: rd_data = '0;
         endcase
      end
   end

   assign bus.rd_data = rd_data;
   assign cnt         = cnt_q;
   assign irq         = ti_q;
   assign irq_any     = |ti_q;
endmodule

// File: tb/tb_csr_timer_array.sv
// Directed bench for csr_timer_array with hand-computed expectations.
// The main instance uses default parameters. A second instance has N_TIMER=3, DIV=4 and CNT_W=8.
module tb_csr_timer_array;
   logic        clk = 1'b0;
   logic        resetn;
   logic        freeze;
   logic [63:0] cnt;
   logic [1:0]  irq;
   logic        irq_any;
   logic [7:0]  cnt2;
   logic [2:0]  irq2;
   logic        irq_any2;

   int vectors     = 0;
   int miscompares = 0;

   csr_timer_array_if #(.TW(32), .CHW(1)) bus  ();
   csr_timer_array_if #(.TW(32), .CHW(2)) bus2 ();

   csr_timer_array #(.N_TIMER(2), .TW(32), .CNT_W(64), .DIV(1)) u_dut (
      .clk     (clk),
      .resetn  (resetn),
      .freeze  (freeze),
      .bus     (bus),
      .cnt     (cnt),
      .irq     (irq),
      .irq_any (irq_any)
   );

   csr_timer_array #(.N_TIMER(3), .TW(32), .CNT_W(8), .DIV(4)) u_dut2 (
      .clk     (clk),
      .resetn  (resetn),
      .freeze  (freeze),
      .bus     (bus2),
      .cnt     (cnt2),
      .irq     (irq2),
      .irq_any (irq_any2)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge. The write is sampled on the next rising edge.
   task automatic wr(input logic [0:0] ch, input logic sel, input logic [31:0] data);
      bus.wr_ch   = ch;
      bus.wr_sel  = sel;
      bus.wr_data = data;
      bus.wr_en   = 1'b1;
      @(negedge clk);
      bus.wr_en   = 1'b0;
   endtask

   task automatic wr2(input logic [1:0] ch, input logic sel, input logic [31:0] data);
      bus2.wr_ch   = ch;
      bus2.wr_sel  = sel;
      bus2.wr_data = data;
      bus2.wr_en   = 1'b1;
      @(negedge clk);
      bus2.wr_en   = 1'b0;
   endtask

   task automatic rd(input logic [0:0] ch, input logic [1:0] sel, output logic [31:0] d);
      bus.rd_ch  = ch;
      bus.rd_sel = sel;
      #1;
      d = bus.rd_data;
   endtask

   task automatic rd2(input logic [1:0] ch, input logic [1:0] sel, output logic [31:0] d);
      bus2.rd_ch  = ch;
      bus2.rd_sel = sel;
      #1;
      d = bus2.rd_data;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      resetn = 1'b0;
      freeze = 1'b0;
      bus.wr_en  = 1'b0; bus.wr_ch  = '0; bus.wr_sel  = 1'b0; bus.wr_data  = '0;
      bus.rd_ch  = '0;   bus.rd_sel = '0;
      bus2.wr_en = 1'b0; bus2.wr_ch = '0; bus2.wr_sel = 1'b0; bus2.wr_data = '0;
      bus2.rd_ch = '0;   bus2.rd_sel = '0;
      #12;
      vectors++;
      if (irq !== 2'b00 || irq_any !== 1'b0) begin
         miscompares++; $display("FAIL reset_irq: got irq=%b any=%b want 00/0", irq, irq_any);
      end
      vectors++;
      if (cnt !== 64'd0 || cnt2 !== 8'd0) begin
         miscompares++; $display("FAIL reset_cnt: got cnt=%0d cnt2=%0d want 0/0", cnt, cnt2);
      end
      rd(1'b0, 2'd1, d);
      vectors++;
      if (d !== 32'd0) begin
         miscompares++; $display("FAIL reset_tval: got %h want 0", d);
      end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_prescaler;
      tick(8);
      vectors++;
      if (cnt !== 64'd8) begin
         miscompares++; $display("FAIL cnt_div1: got %0d want 8", cnt);
      end
      vectors++;
      if (cnt2 !== 8'd2) begin
         miscompares++; $display("FAIL cnt_div4: got %0d want 2", cnt2);
      end
      tick(1012);
      vectors++;
      if (cnt2 !== 8'hFF) begin
         miscompares++; $display("FAIL cnt_pre_wrap: got %h want ff", cnt2);
      end
      tick(4);
      vectors++;
      if (cnt2 !== 8'h00) begin
         miscompares++; $display("FAIL cnt_wrap: got %h want 00", cnt2);
      end
   endtask

   task automatic test_range;
      logic [31:0] d;
      wr2(2'd3, 1'b0, 32'h0000_000D);
      wr2(2'd2, 1'b0, 32'h0000_0105);
      rd2(2'd2, 2'd0, d);
      vectors++;
      if (d !== 32'h0000_0105) begin
         miscompares++; $display("FAIL range_ch2_tcfg: got %h want 00000105", d);
      end
      rd2(2'd3, 2'd0, d);
      vectors++;
      if (d !== 32'd0) begin
         miscompares++; $display("FAIL range_rd_oob_tcfg: got %h want 0", d);
      end
      rd2(2'd3, 2'd1, d);
      vectors++;
      if (d !== 32'd0) begin
         miscompares++; $display("FAIL range_rd_oob_tval: got %h want 0", d);
      end
      wr(1'b0, 1'b0, 32'h0000_0104);
      rd(1'b0, 2'd3, d);
      vectors++;
      if (d !== 32'd0) begin
         miscompares++; $display("FAIL rd_sel3: got %h want 0", d);
      end
      wr(1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_one_shot;
      logic [31:0] d;
      wr(1'b0, 1'b0, 32'h0000_000D);
      rd(1'b0, 2'd1, d);
      vectors++;
      if (d !== 32'd12) begin
         miscompares++; $display("FAIL oneshot_load: got %0d want 12", d);
      end
      tick(12);
      rd(1'b0, 2'd1, d);
      vectors++;
      if (d !== 32'd0 || irq[0] !== 1'b0) begin
         miscompares++; $display("FAIL oneshot_e12: got tval=%0d ti=%b want 0/0", d, irq[0]);
      end
      tick(1);
      rd(1'b0, 2'd1, d);
      vectors++;
      if (irq !== 2'b01 || irq_any !== 1'b1 || d !== 32'hFFFF_FFFF) begin
         miscompares++;
         $display("FAIL oneshot_e13: got irq=%b any=%b tval=%h want 01/1/ffffffff", irq, irq_any, d);
      end
      tick(50);
      rd(1'b0, 2'd1, d);
      vectors++;
      if (d !== 32'hFFFF_FFFF || irq !== 2'b01) begin
         miscompares++; $display("FAIL oneshot_hold: got tval=%h irq=%b want ffffffff/01", d, irq);
      end
      rd(1'b0, 2'd2, d);
      vectors++;
      if (d !== 32'd1) begin
         miscompares++; $display("FAIL oneshot_status: got %h want 1", d);
      end
      wr(1'b0, 1'b1, 32'h0000_0001);
      vectors++;
      if (irq !== 2'b00 || irq_any !== 1'b0) begin
         miscompares++; $display("FAIL ticlr: got irq=%b any=%b want 00/0", irq, irq_any);
      end
   endtask

   task automatic test_periodic;
      logic [31:0] d;
      wr(1'b1, 1'b0, 32'h0000_000B);
      rd(1'b1, 2'd1, d);
      vectors++;
      if (d !== 32'd8) begin
         miscompares++; $display("FAIL per_load: got %0d want 8", d);
      end
      tick(8);
      vectors++;
      if (irq[1] !== 1'b0) begin
         miscompares++; $display("FAIL per_e8: got ti=%b want 0", irq[1]);
      end
      tick(1);
      rd(1'b1, 2'd1, d);
      vectors++;
      if (irq[1] !== 1'b1 || d !== 32'd8) begin
         miscompares++; $display("FAIL per_e9: got ti=%b tval=%0d want 1/8", irq[1], d);
      end
      wr(1'b1, 1'b1, 32'h0000_0001);
      rd(1'b1, 2'd1, d);
      vectors++;
      if (irq[1] !== 1'b0 || d !== 32'd7) begin
         miscompares++; $display("FAIL per_e10: got ti=%b tval=%0d want 0/7", irq[1], d);
      end
      tick(7);
      vectors++;
      if (irq[1] !== 1'b0) begin
         miscompares++; $display("FAIL per_e17: got ti=%b want 0", irq[1]);
      end
      tick(1);
      vectors++;
      if (irq[1] !== 1'b1) begin
         miscompares++; $display("FAIL per_e18: got ti=%b want 1", irq[1]);
      end
      rd(1'b0, 2'd1, d);
      vectors++;
      if (d !== 32'hFFFF_FFFF || irq[0] !== 1'b0) begin
         miscompares++; $display("FAIL per_ch0_idle: got tval=%h ti=%b want ffffffff/0", d, irq[0]);
      end
      wr(1'b1, 1'b0, 32'h0);
      wr(1'b1, 1'b1, 32'h1);
   endtask

   task automatic test_collision;
      logic [31:0] d;
      wr(1'b0, 1'b0, 32'h0000_0005);
      tick(4);
      wr(1'b0, 1'b1, 32'h0000_0001);
      vectors++;
      if (irq[0] !== 1'b1) begin
         miscompares++; $display("FAIL coll_ticlr: got ti=%b want 1", irq[0]);
      end
      wr(1'b0, 1'b1, 32'h0000_0001);
      wr(1'b0, 1'b0, 32'h0000_0005);
      tick(4);
      wr(1'b0, 1'b0, 32'h0000_0021);
      rd(1'b0, 2'd1, d);
      vectors++;
      if (irq[0] !== 1'b0 || d !== 32'd32) begin
         miscompares++; $display("FAIL coll_tcfg: got ti=%b tval=%0d want 0/32", irq[0], d);
      end
      wr(1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_freeze;
      logic [31:0] d;
      logic [63:0] c0;
      wr(1'b0, 1'b0, 32'h0000_000D);
      tick(3);
      freeze = 1'b1;
      c0 = cnt;
      tick(5);
      freeze = 1'b0;
      rd(1'b0, 2'd1, d);
      vectors++;
      if (d !== 32'd9) begin
         miscompares++; $display("FAIL frz_hold: got tval=%0d want 9", d);
      end
      vectors++;
      if (cnt !== c0 + 64'd5) begin
         miscompares++; $display("FAIL frz_cnt: got %0d want %0d", cnt, c0 + 64'd5);
      end
      tick(9);
      vectors++;
      if (irq[0] !== 1'b0) begin
         miscompares++; $display("FAIL frz_e17: got ti=%b want 0", irq[0]);
      end
      tick(1);
      vectors++;
      if (irq[0] !== 1'b1) begin
         miscompares++; $display("FAIL frz_e18: got ti=%b want 1", irq[0]);
      end
      freeze = 1'b1;
      wr(1'b1, 1'b0, 32'h0000_0011);
      tick(3);
      rd(1'b1, 2'd1, d);
      vectors++;
      if (d !== 32'd16) begin
         miscompares++; $display("FAIL frz_write: got tval=%0d want 16", d);
      end
      freeze = 1'b0;
      wr(1'b1, 1'b0, 32'h0);
   endtask

   task automatic test_async_reset;
      logic [31:0] d;
      wr(1'b0, 1'b1, 32'h1);
      wr(1'b0, 1'b0, 32'h0000_000B);
      tick(10);
      rd(1'b0, 2'd1, d);
      vectors++;
      if (d !== 32'd7 || irq[0] !== 1'b1) begin
         miscompares++; $display("FAIL arst_pre: got tval=%0d ti=%b want 7/1", d, irq[0]);
      end
      #1;
      resetn = 1'b0;
      rd(1'b0, 2'd1, d);
      vectors++;
      if (d !== 32'd0 || irq !== 2'b00 || irq_any !== 1'b0 || cnt !== 64'd0) begin
         miscompares++;
         $display("FAIL arst_now: got tval=%0d irq=%b any=%b cnt=%0d want 0/00/0/0", d, irq, irq_any, cnt);
      end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      test_reset();
      test_prescaler();
      test_range();
      test_one_shot();
      test_periodic();
      test_collision();
      test_freeze();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
